// File: rtl/cmult_pkg.sv
// Shared definitions for the complex-multiply sequencer: FSM state encoding,
// multiplier operand-select codes and small decode helpers.
package cmult_pkg;

    localparam int unsigned NUM_STATES = 7;
    localparam int unsigned STATE_W    = $clog2(NUM_STATES);

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_MUL_RR = 3'd1,
        ST_MUL_II = 3'd2,
        ST_MUL_RI = 3'd3,
        ST_MUL_IR = 3'd4,
        ST_ADD    = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Operand mux codes: which partial product sits on the shared multiplier.
    localparam logic [1:0] SEL_RR = 2'b00;  // re1 * re2
    localparam logic [1:0] SEL_II = 2'b01;  // im1 * im2
    localparam logic [1:0] SEL_RI = 2'b10;  // re1 * im2
    localparam logic [1:0] SEL_IR = 2'b11;  // im1 * re2

    // Width of a counter that must reach m-1 (never less than one bit).
    function automatic int unsigned wait_cnt_width(input int unsigned m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic is_mul_state(input state_t s);
        return (s == ST_MUL_RR) || (s == ST_MUL_II) ||
               (s == ST_MUL_RI) || (s == ST_MUL_IR);
    endfunction

    // Operand select per state; non-multiply states park on SEL_RR.
    function automatic logic [1:0] sel_of_state(input state_t s);
        logic [1:0] sel;
        case (s)
            ST_MUL_II: sel = SEL_II;
            ST_MUL_RI: sel = SEL_RI;
            ST_MUL_IR: sel = SEL_IR;
            default:   sel = SEL_RR;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/mult_wait_cnt.sv
// Hold counter for the multicycle multiplier: counts 0..MULT_CYCLES-1 while
// enabled, clears on request, and flags the final count. With MULT_CYCLES=1
// the count is pinned at zero and 'last' is permanently high.
module mult_wait_cnt
    import cmult_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int unsigned   CW       = wait_cnt_width(MULT_CYCLES);
    localparam logic [CW-1:0] LAST_VAL = CW'(MULT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Count cycles spent in the current multiply state; clear has priority.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Last hold cycle of the current product.
    always_comb begin
        last = (cnt == LAST_VAL);
    end

endmodule

// File: rtl/cmult_seq_ctrl.sv
// Control sequencer for a complex multiplier that time-shares one real
// multiplier across the four partial products rr, ii, ri, ir.
// Optional feature: define CMULT_PERF_CNT_EN to add the op_count port and
// its completed-transaction counter.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Operands: op_ready is high only in IDLE and op_capture marks the
// accepting cycle; op_val outside IDLE is ignored. Result: res_val stays high
// with a stable result until res_ready is seen; neither side may make its
// signal depend combinationally on the other beyond op_capture.
module cmult_seq_ctrl
    import cmult_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sw_rst,
    input  logic             op_val,
    input  logic             res_ready,
    output logic             op_ready,
    output logic             op_capture,
    output logic             res_val,
    output logic [1:0]       op_sel,
    output logic             prod_wr_en,
    output logic             compute_en,
    output logic             busy,
`ifdef CMULT_PERF_CNT_EN
    output logic [CNT_W-1:0] op_count,
`endif
    output state_t           state_dbg
);

    if (MULT_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
        $error("cmult_seq_ctrl: MULT_CYCLES and CNT_W must be at least 1");
    end

    state_t state_q;
    state_t state_d;
    logic   wait_last;
    logic   wait_clr;
    logic   wait_en;

    // Hold counter clears whenever the FSM moves (including software reset).
    always_comb begin
        wait_clr = sw_rst || (state_d != state_q);
        wait_en  = is_mul_state(state_q);
    end

    mult_wait_cnt #(
        .MULT_CYCLES(MULT_CYCLES)
    ) u_wait_cnt (
        .clk (clk),
        .rstn(rstn),
        .clr (wait_clr),
        .en  (wait_en),
        .last(wait_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: software reset wins, multiply states advance on the last hold cycle.
    always_comb begin
        state_d = state_q;
        if (sw_rst) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:   if (op_val)    state_d = ST_MUL_RR;
                ST_MUL_RR: if (wait_last) state_d = ST_MUL_II;
                ST_MUL_II: if (wait_last) state_d = ST_MUL_RI;
                ST_MUL_RI: if (wait_last) state_d = ST_MUL_IR;
                ST_MUL_IR: if (wait_last) state_d = ST_ADD;
                ST_ADD:                   state_d = ST_DONE;
                ST_DONE:   if (res_ready) state_d = ST_IDLE;
                default:                  state_d = ST_IDLE;
            endcase
        end
    end

    // Output decode from the state register; write strobes are suppressed in a
    // software-reset cycle and op_capture is the operand handshake itself.
    always_comb begin
        op_ready   = (state_q == ST_IDLE);
        res_val    = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        op_sel     = sel_of_state(state_q);
        prod_wr_en = is_mul_state(state_q) && wait_last && !sw_rst;
        compute_en = (state_q == ST_ADD) && !sw_rst;
        op_capture = op_val && op_ready && !sw_rst && rstn;
        state_dbg  = state_q;
    end

`ifdef CMULT_PERF_CNT_EN
    // Completed-transaction counter; wraps naturally at its width.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_count <= '0;
        end else if (sw_rst) begin
            op_count <= '0;
        end else if ((state_q == ST_DONE) && res_ready) begin
            op_count <= op_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_cmult_seq_ctrl.sv
// Bench for cmult_seq_ctrl: two instances (MULT_CYCLES=1 and 3) share one
// stimulus stream. A transaction-level model predicts every output each cycle;
// a small datapath on the M=1 instance checks that the strobes produce the
// right complex product through an expected-result queue.
module tb_cmult_seq_ctrl;
    import cmult_pkg::*;

    localparam int unsigned M_A  = 1;
    localparam int unsigned M_B  = 3;
    localparam int unsigned CW_A = 16;
    localparam int unsigned CW_B = 2;

    // ---------------- clock / reset ----------------
    logic clk       = 1'b0;
    logic rstn      = 1'b0;
    logic sw_rst    = 1'b0;
    logic op_val    = 1'b0;
    logic res_ready = 1'b0;

    always #5 clk = ~clk;

    logic       a_op_ready, a_op_capture, a_res_val, a_prod_wr_en, a_compute_en, a_busy;
    logic [1:0] a_op_sel;
    logic       b_op_ready, b_op_capture, b_res_val, b_prod_wr_en, b_compute_en, b_busy;
    logic [1:0] b_op_sel;
    state_t     a_state_dbg, b_state_dbg;
`ifdef CMULT_PERF_CNT_EN
    logic [CW_A-1:0] a_op_count;
    logic [CW_B-1:0] b_op_count;
`endif

    cmult_seq_ctrl #(.MULT_CYCLES(M_A), .CNT_W(CW_A)) u_a (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .op_val(op_val), .res_ready(res_ready),
        .op_ready(a_op_ready), .op_capture(a_op_capture), .res_val(a_res_val),
        .op_sel(a_op_sel), .prod_wr_en(a_prod_wr_en), .compute_en(a_compute_en),
        .busy(a_busy),
`ifdef CMULT_PERF_CNT_EN
        .op_count(a_op_count),
`endif
        .state_dbg(a_state_dbg)
    );

    cmult_seq_ctrl #(.MULT_CYCLES(M_B), .CNT_W(CW_B)) u_b (
        .clk(clk), .rstn(rstn), .sw_rst(sw_rst), .op_val(op_val), .res_ready(res_ready),
        .op_ready(b_op_ready), .op_capture(b_op_capture), .res_val(b_res_val),
        .op_sel(b_op_sel), .prod_wr_en(b_prod_wr_en), .compute_en(b_compute_en),
        .busy(b_busy),
`ifdef CMULT_PERF_CNT_EN
        .op_count(b_op_count),
`endif
        .state_dbg(b_state_dbg)
    );

    // Bit order: [7] op_ready [6] op_capture [5] res_val [4:3] op_sel
    //            [2] prod_wr_en [1] compute_en [0] busy
    logic [7:0] a_vec, b_vec, snap_a, snap_b;
    assign a_vec = {a_op_ready, a_op_capture, a_res_val, a_op_sel, a_prod_wr_en, a_compute_en, a_busy};
    assign b_vec = {b_op_ready, b_op_capture, b_res_val, b_op_sel, b_prod_wr_en, b_compute_en, b_busy};

    // ---------------- datapath driven by instance A ----------------
    logic signed [7:0]  in_re1, in_im1, in_re2, in_im2;
    logic signed [7:0]  d_re1, d_im1, d_re2, d_im2;
    logic signed [15:0] prod [4];
    logic signed [16:0] res_re, res_im;

    always @(posedge clk) begin
        if (a_op_capture) begin
            d_re1 <= in_re1; d_im1 <= in_im1; d_re2 <= in_re2; d_im2 <= in_im2;
        end
        if (a_prod_wr_en) begin
            case (a_op_sel)
                2'd0:    prod[0] <= 16'(d_re1) * 16'(d_re2);
                2'd1:    prod[1] <= 16'(d_im1) * 16'(d_im2);
                2'd2:    prod[2] <= 16'(d_re1) * 16'(d_im2);
                default: prod[3] <= 16'(d_im1) * 16'(d_re2);
            endcase
        end
        if (a_compute_en) begin
            res_re <= 17'(prod[0]) - 17'(prod[1]);
            res_im <= 17'(prod[2]) + 17'(prod[3]);
        end
    end

    // ---------------- scoreboard / model state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [33:0] exp_q[$];

    int unsigned m_mult [2];
    bit          m_busy [2];
    int unsigned m_t    [2];
    int unsigned m_cnt  [2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Expected outputs for the current cycle, from the time elapsed since capture.
    function automatic logic [7:0] model_out(input int i, input bit ov, input bit sr);
        int unsigned mm;
        int unsigned t;
        logic [1:0]  ks;
        bit          pw;
        mm = m_mult[i];
        t  = m_t[i];
        if (!m_busy[i]) return {1'b1, ov & ~sr, 6'b000000};
        if (t <= 4 * mm) begin
            ks = 2'((t - 1) / mm);
            pw = (((t - 1) % mm) == (mm - 1)) && !sr;
            return {3'b000, ks, pw, 1'b0, 1'b1};
        end
        if (t == 4 * mm + 1) return {5'b00000, 1'b0, !sr, 1'b1};
        return 8'b0010_0001;
    endfunction

    function automatic void model_step(input int i, input bit ov, input bit rr, input bit sr);
        if (sr) begin
            m_busy[i] = 1'b0;
            m_cnt[i]  = 0;
        end else if (!m_busy[i]) begin
            if (ov) begin
                m_busy[i] = 1'b1;
                m_t[i]    = 1;
            end
        end else if (m_t[i] >= 4 * m_mult[i] + 2 && rr) begin
            m_busy[i] = 1'b0;
            m_cnt[i]  = m_cnt[i] + 1;
        end else begin
            m_t[i] = m_t[i] + 1;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0;
            m_t[i]    = 0;
            m_cnt[i]  = 0;
        end
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge: apply inputs, check at the falling edge,
    // advance the model at the next rising edge.
    task automatic drive_cycle(input bit ov, input bit rr, input bit sr);
        logic [33:0] exp_res;
        int          e_re, e_im;
        op_val = ov; res_ready = rr; sw_rst = sr;
        @(negedge clk);
        snap_a = a_vec;
        snap_b = b_vec;
        check("outputs_m1", 64'(a_vec), 64'(model_out(0, ov, sr)));
        check("outputs_m3", 64'(b_vec), 64'(model_out(1, ov, sr)));
`ifdef CMULT_PERF_CNT_EN
        check("op_count_m1", 64'(a_op_count), 64'(m_cnt[0] % (1 << CW_A)));
        check("op_count_m3", 64'(b_op_count), 64'(m_cnt[1] % (1 << CW_B)));
`endif
        if (m_busy[0] && m_t[0] == 4 * M_A + 2) begin
            check("result_queue_size", 64'(exp_q.size()), 64'(1));
            if (exp_q.size() > 0) begin
                exp_res = exp_q.pop_front();
                check("datapath_result", 64'({res_re, res_im}), 64'(exp_res));
            end
        end
        if (!m_busy[0] && ov && !sr) begin
            e_re = int'(in_re1) * int'(in_re2) - int'(in_im1) * int'(in_im2);
            e_im = int'(in_re1) * int'(in_im2) + int'(in_im1) * int'(in_re2);
            exp_q.push_back({17'(e_re), 17'(e_im)});
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, ov, rr, sr);
        if (sr) exp_q.delete();
        #1;
    endtask

    task automatic async_reset_mid();
        op_val = 1'b1; sw_rst = 1'b0;
        rstn = 1'b0;
        #1;
        check("async_reset_m1", 64'(a_vec), 64'(8'b1000_0000));
        check("async_reset_m3", 64'(b_vec), 64'(8'b1000_0000));
`ifdef CMULT_PERF_CNT_EN
        check("async_reset_cnt_m1", 64'(a_op_count), 64'(0));
`endif
        op_val = 1'b0;
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic random_operands();
        in_re1 = 8'($urandom_range(255)); in_im1 = 8'($urandom_range(255));
        in_re2 = 8'($urandom_range(255)); in_im2 = 8'($urandom_range(255));
    endtask

    // ---------------- test ----------------
    typedef struct {
        bit         ov;
        bit         rr;
        bit         sr;
        logic [7:0] exp_a;
    } vec_t;

    vec_t tab [8];
    int   rv_cnt;

    initial begin
        // Basic (3+2j)*(1+4j) with M=1, res_ready held high.
        tab[0] = '{1'b1, 1'b1, 1'b0, 8'b1100_0000};  // IDLE, capture
        tab[1] = '{1'b0, 1'b1, 1'b0, 8'b0000_0101};  // RR
        tab[2] = '{1'b0, 1'b1, 1'b0, 8'b0000_1101};  // II
        tab[3] = '{1'b0, 1'b1, 1'b0, 8'b0001_0101};  // RI
        tab[4] = '{1'b0, 1'b1, 1'b0, 8'b0001_1101};  // IR
        tab[5] = '{1'b0, 1'b1, 1'b0, 8'b0000_0011};  // ADD
        tab[6] = '{1'b0, 1'b1, 1'b0, 8'b0010_0001};  // DONE
        tab[7] = '{1'b0, 1'b1, 1'b0, 8'b1000_0000};  // IDLE again

        m_mult[0] = M_A;
        m_mult[1] = M_B;
        model_reset();
        in_re1 = 8'sd0; in_im1 = 8'sd0; in_re2 = 8'sd0; in_im2 = 8'sd0;

        // Reset state: op_val high must not leak into op_capture.
        op_val = 1'b1;
        #12;
        check("reset_vec_m1", 64'(a_vec), 64'(8'b1000_0000));
        check("reset_vec_m3", 64'(b_vec), 64'(8'b1000_0000));
        check("reset_state_dbg", 64'(a_state_dbg), 64'(ST_IDLE));
`ifdef CMULT_PERF_CNT_EN
        check("reset_op_count", 64'(a_op_count), 64'(0));
`endif
        op_val = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Basic sequence: table for M=1, fixed points for M=3.
        in_re1 = 8'sd3; in_im1 = 8'sd2; in_re2 = 8'sd1; in_im2 = 8'sd4;
        for (int j = 0; j < 17; j++) begin
            if (j < 8) begin
                drive_cycle(tab[j].ov, tab[j].rr, tab[j].sr);
                check($sformatf("basic_tab_%0d", j), 64'(snap_a), 64'(tab[j].exp_a));
            end else begin
                drive_cycle(1'b0, 1'b1, 1'b0);
            end
            if (j == 7) begin
                check("basic_res_re", 64'(int'(res_re)), 64'(-5));
                check("basic_res_im", 64'(int'(res_im)), 64'(14));
            end
            if (j >= 1 && j <= 12) check("m3_prod_wr_en", 64'(snap_b[2]), 64'(j % 3 == 0));
            if (j == 13) check("m3_compute_en", 64'(snap_b[1]), 64'(1));
            if (j == 14) check("m3_res_val", 64'(snap_b[5]), 64'(1));
        end

        // Back-pressure: res_ready low until cycle 17.
        in_re1 = -8'sd7; in_im1 = 8'sd9; in_re2 = 8'sd11; in_im2 = -8'sd6;
        rv_cnt = 0;
        for (int j = 0; j < 19; j++) begin
            drive_cycle(j == 0, j >= 17, 1'b0);
            rv_cnt += int'(snap_a[5]);
            if (j == 18) check("bp_idle_after_ready", 64'(snap_a[7]), 64'(1));
        end
        check("bp_res_val_cycles", 64'(rv_cnt), 64'(12));

        // op_val pulse during MUL_II must be dropped.
        in_re1 = 8'sd5; in_im1 = -8'sd3; in_re2 = -8'sd2; in_im2 = 8'sd7;
        for (int j = 0; j < 17; j++) begin
            if (j == 2) begin
                in_re1 = 8'sd100; in_im1 = 8'sd100; in_re2 = 8'sd100; in_im2 = 8'sd100;
            end
            drive_cycle(j == 0 || j == 2, 1'b1, 1'b0);
            if (j == 2) check("drop_no_capture", 64'(snap_a[6]), 64'(0));
        end

        // Software reset in MUL_RI, then sw_rst together with op_val in IDLE.
        random_operands();
        for (int j = 0; j < 6; j++) begin
            drive_cycle(j == 0, 1'b1, j == 3);
            if (j == 3) check("swrst_no_prod_wr", 64'(snap_a[2]), 64'(0));
            if (j == 4) begin
                check("swrst_idle_ready", 64'(snap_a[7]), 64'(1));
                check("swrst_not_busy", 64'(snap_a[0]), 64'(0));
`ifdef CMULT_PERF_CNT_EN
                check("swrst_op_count", 64'(a_op_count), 64'(0));
`endif
            end
        end
        drive_cycle(1'b1, 1'b1, 1'b1);
        check("swrst_blocks_capture", 64'(snap_a[6]), 64'(0));
        drive_cycle(1'b0, 1'b1, 1'b0);
        check("swrst_op_not_taken", 64'(snap_a[0]), 64'(0));

        // rstn asserted while in ADD, then three complete ops.
        random_operands();
        for (int j = 0; j < 5; j++) drive_cycle(j == 0, 1'b1, 1'b0);
        check("pre_reset_in_add", 64'(a_compute_en), 64'(1));
        async_reset_mid();
        for (int k = 0; k < 3; k++) begin
            random_operands();
            drive_cycle(1'b1, 1'b1, 1'b0);
            for (int j = 0; j < 6; j++) drive_cycle(1'b0, 1'b1, 1'b0);
        end
`ifdef CMULT_PERF_CNT_EN
        check("perf_three_ops", 64'(a_op_count), 64'(3));
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            random_operands();
            drive_cycle(bit'($urandom_range(1)), $urandom_range(9) < 6, $urandom_range(49) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
